systolic_feeder: RTL
====================

# systolic_feeder

Upstream controller and operand sequencer for the 3x3 `SystolicArray`.
- Holds two N×N operand matrices, A and B, loaded through a simple write port.
- On `start`, it clears the array, streams the operands one column of A and one row of B per cycle, then flushes with zeros.
- It captures the array's 9×16-bit result when the array raises `valid`.
- It re-presents the result to downstream logic with a one-cycle `done` pulse, and flags an error if the array never responds.

## Interface
- `N`, 3, matrix dimension; number of lanes and feed cycles.
- `DATA_W`, 8, operand element width.
- `ACC_W`, 16, result element width.
- `FLUSH_CYCLES`, 1, zero-input cycles after the last feed cycle.
- `TIMEOUT`, 16, maximum WAIT cycles before abort.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  operand write strobe.
- `wr_sel`  in  1  write target: 0 = A, 1 = B.
- `wr_addr`  in  4  element index, row*N+col (0..8).
- `wr_data`  in  DATA_W  element value.
- `start`  in  1  begin a multiply job.
- `busy`  out  1  high in every state except IDLE.
- `sa_rst_n`  out  1  array clear, active-low; drives the array's `rst`.
- `sa_a`  out  N*DATA_W  A lanes; lane i is `sa_a[i*DATA_W+:DATA_W]` (array's `A`).
- `sa_b`  out  N*DATA_W  B lanes; lane j is `sa_b[j*DATA_W+:DATA_W]` (array's `B`).
- `sa_c`  in  N*N*ACC_W  array result; element `r*N+c` is at `sa_c[(r*N+c)*ACC_W+:ACC_W]`.
- `sa_valid`  in  1  array result valid (level).
- `res_c`  out  N*N*ACC_W  captured result, same packing as `sa_c`.
- `done`  out  1  one-cycle pulse when `res_c` is updated.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- Storage: two N×N register arrays, A and B.
  - While in IDLE, a write with `wr_en=1` stores `wr_data` at `wr_addr` of the array chosen by `wr_sel`.
  - Writes with `wr_addr >= N*N` are dropped.
  - Writes are ignored while `busy=1`.
- FSM states: IDLE, CLEAR, FEED, FLUSH, WAIT, DONE.
- IDLE:
  - Lanes are driven with 0; `sa_rst_n=1`.
  - `start=1` moves to CLEAR.
  - If a write and `start` arrive in the same cycle, the write is committed and used by this job.
- CLEAR: one cycle with `sa_rst_n=0` and zero lanes, then FEED with k=0.
- FEED, k = 0..N-1, one cycle each:
  - `sa_a` lane i = A[i][k].
  - `sa_b` lane j = B[k][j].
  - Unused upper bits are zero.
  - After k = N-1, move to FLUSH.
- FLUSH: FLUSH_CYCLES cycles of zero lanes, then WAIT.
- WAIT:
  - Lanes are zero; the timeout counter counts from 0.
  - First cycle with `sa_valid=1`: latch `sa_c` into `res_c` and move to DONE.
  - Counter reaching TIMEOUT without `sa_valid`: pulse `err` and return to IDLE; `res_c` is unchanged.
- DONE: `done=1` for exactly one cycle, then IDLE.
- `sa_valid` is ignored outside WAIT.
- `start` while `busy` is ignored; it is not queued.
- Operand storage is preserved across jobs, so an identical job can be re-run with `start` alone.
- No arithmetic is performed; `res_c` is a bit-exact copy of `sa_c`.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE; `busy=0`, `done=0`, `err=0`.
  - `sa_a=0`, `sa_b=0`, `res_c=0`.
  - `sa_rst_n=0` while `rst=1`, so the array is held clear; it returns to 1 the cycle after `rst` deasserts.
  - Operand storage resets to 0.
- Cycle schedule, with `start` sampled at edge t:
  - CLEAR is visible in cycle t+1.
  - FEED k=0..N-1 in cycles t+2 .. t+N+1.
  - FLUSH in t+N+2 .. t+N+1+FLUSH_CYCLES.
  - WAIT from t+N+2+FLUSH_CYCLES.
- If `sa_valid` is sampled high at edge w, `res_c` and `done` are valid in cycle w+1.
- Back-to-back jobs: `start` may be asserted in the DONE cycle but is ignored, because DONE counts as busy. The earliest accepted `start` is the first IDLE cycle.
- Reset mid-job, in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - No `done` or `err` is generated.
  - Storage is cleared.

## Test plan
- Load A = B = [[1,2,3],[4,5,6],[7,8,9]], then `start`:
  - FEED k=0 drives `sa_a`={7,4,1} and `sa_b`={3,2,1}, MSB lane first.
  - `res_c` = {30,36,42,66,81,96,102,126,150} (element 0 first).
  - `done` is a single pulse.
- Reload B = [[9,8,7],[6,5,4],[3,2,1]] with the same A, then `start`:
  - `res_c` = {30,24,18,84,69,54,138,114,90}.
  - `sa_rst_n` is low for exactly one cycle before FEED.
- Issue a second `start` in the same cycle as a B write:
  - The write is committed and used by the job.
  - A mid-FEED `start` and mid-FEED writes are ignored.
  - Stored operands are unchanged.
- Hold `sa_valid=0` via a stub array:
  - `err` pulses at WAIT entry + TIMEOUT cycles.
  - FSM returns to IDLE; `res_c` still holds the previous result.
- Assert `rst` during FEED k=1:
  - Next cycle shows `busy=0`, lanes 0, `sa_rst_n=0`.
  - After release, a reloaded job completes correctly.
- Set `wr_addr`=9 with `wr_data`=5: storage is unchanged, and the next job's result matches the unmodified matrices.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand store and job sequencer for a 3x3 systolic array: feeds A columns and
// B rows, waits for the array result, captures it and reports done or timeout.
module systolic_feeder #(
  parameter int N            = 3,
  parameter int DATA_W       = 8,
  parameter int ACC_W        = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [3:0]             wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   sa_rst_n,
  output logic [N*DATA_W-1:0]    sa_a,
  output logic [N*DATA_W-1:0]    sa_b,
  input  logic [N*N*ACC_W-1:0]   sa_c,
  input  logic                   sa_valid,
  output logic [N*N*ACC_W-1:0]   res_c,
  output logic                   done,
  output logic                   err
);
  // state   | meaning
  // S_IDLE  | lanes zero, operand writes accepted, wait for start
  // S_CLEAR | one cycle of array clear (sa_rst_n low)
  // S_FEED  | N cycles: column k of A, row k of B on the lanes
  // S_FLUSH | FLUSH_CYCLES cycles of zero lanes
  // S_WAIT  | wait for sa_valid, bounded by TIMEOUT cycles
  // S_DONE  | one-cycle done pulse with res_c updated

  localparam int MAXC = (TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int KW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(TIMEOUT - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_WAIT, S_DONE} state_t;

  state_t            state, nstate;
  logic [CW-1:0]     cnt, ncnt;
  logic [KW-1:0]     kidx, nk;
  logic [DATA_W-1:0] mem_a [N][N];
  logic [DATA_W-1:0] mem_b [N][N];

  logic                n_rst_n, n_done, n_err;
  logic [N*DATA_W-1:0] n_a, n_b;

  always_comb begin
    nstate  = state;
    ncnt    = cnt;
    nk      = kidx;
    n_err   = 1'b0;
    n_done  = 1'b0;
    n_rst_n = 1'b1;
    n_a     = '0;
    n_b     = '0;
    case (state)
      S_IDLE:  if (start) nstate = S_CLEAR;
      S_CLEAR: begin
        nstate = S_FEED;
        nk     = '0;
      end
      S_FEED: begin
        if (kidx == K_LAST) begin
          if (FLUSH_CYCLES == 0) begin
            nstate = S_WAIT;
            ncnt   = WAIT_LD;
          end else begin
            nstate = S_FLUSH;
            ncnt   = FLUSH_LD;
          end
        end else begin
          nk = kidx + 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          nstate = S_WAIT;
          ncnt   = WAIT_LD;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (sa_valid) begin
          nstate = S_DONE;
        end else if (cnt == '0) begin
          nstate = S_IDLE;
          n_err  = 1'b1;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    n_rst_n = (nstate != S_CLEAR);
    n_done  = (nstate == S_DONE);
    if (nstate == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        n_a[i*DATA_W +: DATA_W] = mem_a[i][nk];
        n_b[i*DATA_W +: DATA_W] = mem_b[nk][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      kidx     <= '0;
      busy     <= 1'b0;
      sa_rst_n <= 1'b0;
      sa_a     <= '0;
      sa_b     <= '0;
      res_c    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_a[r][c] <= '0;
          mem_b[r][c] <= '0;
        end
      end
    end else begin
      state    <= nstate;
      cnt      <= ncnt;
      kidx     <= nk;
      busy     <= (nstate != S_IDLE);
      sa_rst_n <= n_rst_n;
      sa_a     <= n_a;
      sa_b     <= n_b;
      done     <= n_done;
      err      <= n_err;
      if (state == S_WAIT && sa_valid) res_c <= sa_c;
      // Address decode: out-of-range addresses match no element and are dropped.
      if (state == S_IDLE && wr_en) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            if (wr_addr == 4'(r*N + c)) begin
              if (wr_sel) mem_b[r][c] <= wr_data;
              else        mem_a[r][c] <= wr_data;
            end
          end
        end
      end
    end
  end

endmodule
